sum_stream_arbiter: RTL and testbench



---
 rtl/sum_stream_arbiter.sv | 138 +++++++++++++
 tb/tb_sum_stream_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_stream_arbiter.sv
// Round-robin arbiter that lends a single stream-summing engine to one of N requesters
// at a time: start pulse, element pass-through, result capture with a completion watchdog.
module sum_stream_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] s_data,
  input  logic [N-1:0]   s_valid,
  input  logic [N-1:0]   s_last,
  output logic [N-1:0]   s_ready,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           eng_start,
  output logic [W-1:0]   eng_s,
  output logic           eng_s_valid,
  output logic           eng_s_last,
  input  logic           eng_s_ready,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_sum
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [CW-1:0] tcnt;

  logic [IW:0]   cand;
  logic [IW-1:0] pick;
  logic          found;
  logic          in_stream;
  logic          xfer_last;

  // First requesting index at or after the pointer, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign in_stream = (state == S_STREAM);

  // Unbuffered pass-through: the handshake happens directly between owner and engine.
  always_comb begin
    s_ready     = '0;
    eng_s       = '0;
    eng_s_valid = 1'b0;
    eng_s_last  = 1'b0;
    if (in_stream) begin
      eng_s          = s_data[int'(owner)*W +: W];
      eng_s_valid    = s_valid[owner];
      eng_s_last     = s_last[owner];
      s_ready[owner] = eng_s_ready;
    end
  end

  assign xfer_last = in_stream && eng_s_valid && eng_s_ready && eng_s_last;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      owner     <= '0;
      ptr       <= '0;
      tcnt      <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     <= N'(1) << pick;
            owner     <= pick;
            eng_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: state <= S_STREAM;
        S_STREAM: begin
          if (xfer_last) begin
            tcnt  <= '0;
            state <= S_WAIT;
          end
        end
        // A done arriving on the final watchdog cycle still counts as a normal completion.
        S_WAIT: begin
          if (eng_done) begin
            rsp_data  <= eng_sum;
            rsp_err   <= 1'b0;
            rsp_valid <= grant;
            state     <= S_RESP;
          end else if (tcnt == TLIM) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= grant;
            state     <= S_RESP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        S_RESP: begin
          grant <= '0;
          ptr   <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_stream_arbiter.sv
// Self-checking bench for sum_stream_arbiter: a bench-side summing engine, per-requester
// element sources, a job-level reference model compared every cycle, and directed scenarios.
module tb_sum_stream_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [N-1:0] req, s_valid, s_last, s_ready, grant, rsp_valid;
  logic [N*W-1:0] s_data;
  logic [W-1:0] rsp_data, eng_s, eng_sum;
  logic rsp_err, eng_start, eng_s_valid, eng_s_last, eng_s_ready, eng_done;

  always #5 clk = ~clk;

  sum_stream_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .req(req), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_start(eng_start), .eng_s(eng_s),
    .eng_s_valid(eng_s_valid), .eng_s_last(eng_s_last), .eng_s_ready(eng_s_ready),
    .eng_done(eng_done), .eng_sum(eng_sum)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sources hold {last, data}; the engine sums accepted elements and answers after eng_lat cycles.
  logic [W:0] src_q [N][$];
  bit rdy_q[$];
  bit gate_q[$];
  logic [W-1:0] got[$];
  logic [N-1:0] grant_log[$];
  int eng_lat = 0;
  int eng_cnt = 0;
  bit eng_pending = 0;
  logic [W-1:0] eng_acc = '0;

  int cycle = 0, start_cnt = 0, rsp_cnt = 0, rsp_cycle = 0, last_xfer_cycle = 0, leak = 0;
  logic [N-1:0] prev_grant = '0;

  // Job-level reference model.
  bit m_busy = 0, m_sdone = 0, m_resp = 0, m_err = 0;
  int m_ptr = 0, m_owner = 0, m_age = 0, m_wait = 0;
  logic [W-1:0] m_data = '0;

  always @(posedge clk) begin
    bit gate;
    #1;
    gate = (gate_q.size() > 0) ? gate_q.pop_front() : 1'b1;
    eng_s_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i] = gate;
        s_data[i*W +: W] = src_q[i][0][W-1:0];
        s_last[i] = src_q[i][0][W];
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*W +: W] = '0;
        s_last[i] = 1'b0;
      end
    end
    if (!nrst) eng_done = 1'b0;
    else if (eng_pending && eng_cnt == 0) begin
      eng_done = 1'b1;
      eng_sum = eng_acc;
      eng_pending = 0;
    end else begin
      eng_done = 1'b0;
      if (eng_pending) eng_cnt--;
    end
  end

  // Compare outputs with the model, then advance model, engine and sources for the coming edge.
  always @(negedge clk) begin
    logic [N-1:0] e_grant, e_sready, e_rv;
    bit strm;
    cycle++;
    if (!nrst) begin
      m_busy = 0; m_sdone = 0; m_resp = 0; m_err = 0;
      m_ptr = 0; m_owner = 0; m_age = 0; m_wait = 0; m_data = '0;
      eng_pending = 0; eng_acc = '0;
    end
    strm = m_busy && m_age >= 1 && !m_sdone;
    e_grant = m_busy ? N'(1) << m_owner : '0;
    e_sready = (strm && eng_s_ready) ? N'(1) << m_owner : '0;
    e_rv = m_resp ? e_grant : '0;
    check("grant", grant, e_grant);
    check("eng_start", eng_start, m_busy && m_age == 0);
    check("s_ready", s_ready, e_sready);
    check("eng_s_valid", eng_s_valid, strm && s_valid[m_owner]);
    if (strm) begin
      check("eng_s", eng_s, s_data[m_owner*W +: W]);
      check("eng_s_last", eng_s_last, s_last[m_owner]);
    end
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_data", rsp_data, m_data);
    check("rsp_err", rsp_err, m_err);

    if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
    prev_grant = grant;
    if (eng_start) start_cnt++;
    if (rsp_valid != '0) begin rsp_cnt++; rsp_cycle = cycle; end
    if ((s_ready & ~grant) != '0) leak++;

    if (nrst) begin
      if (m_resp) begin
        m_busy = 0; m_resp = 0; m_ptr = (m_owner + 1) % N;
      end else if (m_busy) begin
        if (m_age == 0) m_age = 1;
        else if (!m_sdone) begin
          if (s_valid[m_owner] && eng_s_ready && s_last[m_owner]) begin
            m_sdone = 1; m_wait = 0;
          end
        end else begin
          m_wait++;
          if (eng_done) begin m_data = eng_sum; m_err = 0; m_resp = 1; end
          else if (m_wait == TIMEOUT) begin m_data = '0; m_err = 1; m_resp = 1; end
        end
      end else if (req != '0) begin
        for (int k = 0; k < N; k++)
          if (!m_busy && req[(m_ptr + k) % N]) begin
            m_busy = 1; m_owner = (m_ptr + k) % N; m_age = 0; m_sdone = 0;
          end
      end
      if (eng_start) eng_acc = '0;
      if (eng_s_valid && eng_s_ready) begin
        got.push_back(eng_s);
        eng_acc += eng_s;
        if (eng_s_last) begin
          last_xfer_cycle = cycle;
          if (eng_lat >= 0) begin eng_pending = 1; eng_cnt = eng_lat; end
        end
      end
      for (int i = 0; i < N; i++)
        if (s_valid[i] && s_ready[i]) void'(src_q[i].pop_front());
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    nrst = 1'b0; req = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] e, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 100);
    if (grant == '0) begin
      checks++; errors++;
      $display("[TB] FAIL %s grant: got none within 100 cycles, expected %0h", tag, e);
    end else check({tag, " grant"}, grant, e);
  endtask

  task automatic wait_rsp(input logic [N-1:0] ev, input logic [W-1:0] ed, input logic ee, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 300);
    if (rsp_valid == '0) begin
      checks++; errors++;
      $display("[TB] FAIL %s rsp: got none within 300 cycles, expected %0h", tag, ev);
    end else begin
      check({tag, " rsp_valid"}, rsp_valid, ev);
      check({tag, " rsp_data"}, rsp_data, ed);
      check({tag, " rsp_err"}, rsp_err, ee);
    end
  endtask

  task automatic applyStimulus();
    logic [W-1:0] exp1[4] = '{8'h01, 8'h02, 8'h03, 8'hFF};
    logic [N-1:0] rr[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] fair[3] = '{4'b0001, 4'b0100, 4'b0001};
    int n, rsp_before;

    // Reset values.
    @(negedge clk); @(negedge clk);
    check("reset grant", grant, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset eng_start", eng_start, 0);
    check("reset s_ready", s_ready, 0);
    @(posedge clk); #1 nrst = 1'b1;

    // Single job with wrapping sum 1+2+3+0xFF = 0x05.
    src_q[1].push_back(9'h001); src_q[1].push_back(9'h002);
    src_q[1].push_back(9'h003); src_q[1].push_back(9'h1FF);
    eng_lat = 1; got.delete(); start_cnt = 0;
    @(posedge clk); #1 req = 4'b0010;
    @(negedge clk); check("t1 grant before edge", grant, 0);
    @(negedge clk); check("t1 grant latency", grant, 4'b0010);
    check("t1 eng_start", eng_start, 1);
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0010, 8'h05, 1'b0, "t1");
    @(negedge clk);
    check("t1 start pulses", start_cnt, 1);
    check("t1 xfer count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t1 element", got[i], exp1[i]);

    // Round robin from reset with all requests held.
    reset_dut();
    src_q[0].push_back(9'h10A); src_q[0].push_back(9'h10E);
    src_q[1].push_back(9'h10B); src_q[2].push_back(9'h10C); src_q[3].push_back(9'h10D);
    grant_log.delete();
    @(posedge clk); #1 req = 4'b1111;
    wait_rsp(4'b0001, 8'd10, 1'b0, "rr0");
    wait_rsp(4'b0010, 8'd11, 1'b0, "rr1");
    wait_rsp(4'b0100, 8'd12, 1'b0, "rr2");
    wait_rsp(4'b1000, 8'd13, 1'b0, "rr3");
    wait_rsp(4'b0001, 8'd14, 1'b0, "rr4");
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("rr grant count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr order", grant_log[i], rr[i]);

    // Fairness: requester 2 joins during job 0 and is served before 0 again.
    reset_dut();
    src_q[0].push_back(9'h114); src_q[0].push_back(9'h115); src_q[2].push_back(9'h116);
    grant_log.delete();
    @(posedge clk); #1 req = 4'b0001;
    wait_grant(4'b0001, "fair0");
    @(posedge clk); #1 req = 4'b0101;
    wait_rsp(4'b0001, 8'd20, 1'b0, "fair0");
    wait_rsp(4'b0100, 8'd22, 1'b0, "fair2");
    wait_grant(4'b0001, "fair0b");
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0001, 8'd21, 1'b0, "fair0b");
    check("fair grant count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) check("fair order", grant_log[i], fair[i]);

    // Backpressure and valid gaps; requester 3 offers data without a grant.
    reset_dut();
    src_q[1].push_back(9'h001); src_q[1].push_back(9'h002); src_q[1].push_back(9'h103);
    src_q[3].push_back(9'h177);
    got.delete(); leak = 0; eng_lat = 2;
    @(posedge clk); #1 req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (!eng_start && n < 50);
    rdy_q = '{1, 0, 0, 1, 1};
    gate_q = '{1, 1, 0, 0, 1, 1};
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0010, 8'd6, 1'b0, "bp");
    check("bp xfer count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("bp element", got[i], i + 1);
    check("bp stray s_ready", leak, 0);
    src_q[3].delete();

    // Watchdog: no done -> error after exactly TIMEOUT wait cycles.
    reset_dut();
    src_q[2].push_back(9'h105); eng_lat = -1;
    @(posedge clk); #1 req = 4'b0100;
    wait_grant(4'b0100, "to");
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0100, 8'd0, 1'b1, "to");
    @(negedge clk);
    check("to wait cycles", rsp_cycle - last_xfer_cycle - 1, TIMEOUT);
    src_q[3].push_back(9'h107); eng_lat = 0;
    @(posedge clk); #1 req = 4'b1000;
    wait_grant(4'b1000, "after to");
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b1000, 8'd7, 1'b0, "after to");
    // Done on the very cycle the watchdog would expire.
    src_q[0].push_back(9'h109); eng_lat = TIMEOUT - 1;
    @(posedge clk); #1 req = 4'b0001;
    wait_grant(4'b0001, "tie");
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0001, 8'd9, 1'b0, "tie");
    @(negedge clk);
    check("tie wait cycles", rsp_cycle - last_xfer_cycle - 1, TIMEOUT);

    // Reset in the middle of requester 3's stream.
    reset_dut();
    src_q[3].push_back(9'h001); src_q[3].push_back(9'h002); src_q[3].push_back(9'h103);
    for (int i = 0; i < 40; i++) rdy_q.push_back(1'b0);
    eng_lat = 0;
    @(posedge clk); #1 req = 4'b0001 << 3;
    wait_grant(4'b1000, "mid");
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    rsp_before = rsp_cnt;
    #2 nrst = 1'b0;
    #1;
    check("mid async grant", grant, 0);
    check("mid async s_ready", s_ready, 0);
    check("mid async eng_s_valid", eng_s_valid, 0);
    check("mid async rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    rdy_q.delete(); src_q[3].delete();
    @(posedge clk); #1 nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid no response", rsp_cnt, rsp_before);
    src_q[0].push_back(9'h104); src_q[3].push_back(9'h105);
    @(posedge clk); #1 req = 4'b1001;
    wait_grant(4'b0001, "post reset");
    @(posedge clk); #1 req = '0;
    wait_rsp(4'b0001, 8'd4, 1'b0, "post reset");
    src_q[3].delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    req = '0; s_valid = '0; s_last = '0; s_data = '0;
    eng_s_ready = 1'b1; eng_done = 1'b0; eng_sum = '0;
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
